// File: rtl/dwrr_pkg.sv
// Shared definitions for the deficit weighted round-robin scheduler.
// Holds the scheduler FSM state encoding and two helpers:
//   ptr_wrap - next requester index with wrap to 0
//   sat_add  - unsigned add saturating at 2^w-1 (w <= MAXW)
package dwrr_pkg;

    localparam int unsigned MAXW  = 32;
    localparam int unsigned MAXW1 = MAXW + 1;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        REFILL = 2'd1,
        CHECK  = 2'd2,
        GRANT  = 2'd3
    } state_t;

    // Next requester index, wrapping n-1 back to 0.
    function automatic int unsigned ptr_wrap(input int unsigned p, input int unsigned n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

    // Saturating add of two w-bit values carried in MAXW-bit containers.
    function automatic logic [MAXW-1:0] sat_add(input logic [MAXW-1:0] a,
                                                input logic [MAXW-1:0] b,
                                                input int unsigned     w);
        logic [MAXW:0] sum;
        logic [MAXW:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (MAXW1'(1) << w) - MAXW1'(1);
        return (sum > lim) ? lim[MAXW-1:0] : sum[MAXW-1:0];
    endfunction

endpackage

// File: rtl/dwrr_defcnt.sv
// Per-requester deficit counter cell.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clear counter to 0 (highest priority)
//   sub_en    - subtract sub_val (floors at 0)
//   add_en    - saturating add of add_val
//   add_val   - quantum to add (QWID bits)
//   sub_val   - granted length to subtract (LWID bits)
//   cnt       - current deficit (QWID bits)
module dwrr_defcnt
    import dwrr_pkg::*;
#(
    parameter int unsigned QWID = 8,
    parameter int unsigned LWID = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            sub_en,
    input  logic            add_en,
    input  logic [QWID-1:0] add_val,
    input  logic [LWID-1:0] sub_val,
    output logic [QWID-1:0] cnt
);

    logic [QWID-1:0] sub_ext;

    assign sub_ext = QWID'(sub_val);

    // Only one of clr/sub/add is requested per cycle by the scheduler; priority is defensive.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (sub_en) begin
            cnt <= (sub_ext > cnt) ? '0 : cnt - sub_ext;
        end else if (add_en) begin
            cnt <= QWID'(sat_add(MAXW'(cnt), MAXW'(add_val), QWID));
        end
    end

endmodule

// File: rtl/dwrr_sched.sv
// Deficit weighted round-robin scheduler.
// One pointer walks the requesters: SCAN skips idle ones (clearing their deficit),
// REFILL adds the quantum once per visit, CHECK grants when the deficit covers the
// head packet, GRANT holds the grant until the datapath reports done.
// Optional build macro DWRR_STRICT0_EN: requester 0 becomes strict priority and is
// granted without deficit accounting whenever it requests in SCAN/CHECK and blk=0.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   reqs            - per-requester head packet pending
//   req_lens        - packed head packet lengths, LWID bits each
//   input_quantums  - packed quantums, QWID bits each
//   blk             - blocks new grants while high
//   done            - granted packet finished (only observed in GRANT)
//   gnt             - registered one-hot grant
//   gnt_len         - granted length (0 when idle)
//   busy            - high while in GRANT
module dwrr_sched
    import dwrr_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned QWID     = 8,
    parameter int unsigned LWID     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQS-1:0]      reqs,
    input  logic [NUM_REQS*LWID-1:0] req_lens,
    input  logic [NUM_REQS*QWID-1:0] input_quantums,
    input  logic                     blk,
    input  logic                     done,
    output logic [NUM_REQS-1:0]      gnt,
    output logic [LWID-1:0]          gnt_len,
    output logic                     busy
);

    localparam int unsigned CNTWID = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    state_t              state, state_nxt;
    logic [CNTWID-1:0]   ptr, ptr_nxt, ptr_inc;
    logic [NUM_REQS-1:0] gnt_nxt;
    logic [LWID-1:0]     gnt_len_nxt;

    logic [NUM_REQS-1:0] clr_vec, add_vec, sub_vec;
    logic [QWID-1:0]     def_cnt  [NUM_REQS];
    logic [QWID-1:0]     quant_arr[NUM_REQS];
    logic [LWID-1:0]     len_arr  [NUM_REQS];

    logic [LWID-1:0]     eff_len;

`ifdef DWRR_STRICT0_EN
    logic                strict_q, strict_nxt;
    logic [LWID-1:0]     eff_len0;
`endif

    // Unpack per-requester fields and instantiate deficit counters.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
        assign quant_arr[i] = input_quantums[i*QWID +: QWID];
        assign len_arr[i]   = req_lens[i*LWID +: LWID];

        dwrr_defcnt #(
            .QWID (QWID),
            .LWID (LWID)
        ) u_defcnt (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr_vec[i]),
            .sub_en  (sub_vec[i]),
            .add_en  (add_vec[i]),
            .add_val (quant_arr[i]),
            .sub_val (gnt_len),
            .cnt     (def_cnt[i])
        );
    end

    // Zero-length packets still cost one unit.
    assign eff_len = (len_arr[ptr] == '0) ? LWID'(1) : len_arr[ptr];
    assign ptr_inc = CNTWID'(ptr_wrap(MAXW'(ptr), NUM_REQS));

`ifdef DWRR_STRICT0_EN
    assign eff_len0 = (len_arr[0] == '0) ? LWID'(1) : len_arr[0];
`endif

    // Next-state, pointer, grant and counter-control decode.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt;
        gnt_len_nxt = gnt_len;
        clr_vec     = '0;
        add_vec     = '0;
        sub_vec     = '0;
`ifdef DWRR_STRICT0_EN
        strict_nxt  = strict_q;
`endif

        case (state)
            SCAN: begin
                if (!reqs[ptr]) begin
                    clr_vec[ptr] = 1'b1;
                    ptr_nxt      = ptr_inc;
                end else begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                add_vec[ptr] = 1'b1;
                state_nxt    = CHECK;
            end
            CHECK: begin
                if (!reqs[ptr]) begin
                    clr_vec[ptr] = 1'b1;
                    ptr_nxt      = ptr_inc;
                    state_nxt    = SCAN;
                end else if (blk) begin
                    state_nxt = CHECK;
                end else if (def_cnt[ptr] >= QWID'(eff_len)) begin
                    gnt_nxt      = '0;
                    gnt_nxt[ptr] = 1'b1;
                    gnt_len_nxt  = eff_len;
                    state_nxt    = GRANT;
                end else begin
                    ptr_nxt   = ptr_inc;
                    state_nxt = SCAN;
                end
            end
            GRANT: begin
                if (done) begin
`ifdef DWRR_STRICT0_EN
                    sub_vec[ptr] = !strict_q;
                    strict_nxt   = 1'b0;
`else
                    sub_vec[ptr] = 1'b1;
`endif
                    gnt_nxt     = '0;
                    gnt_len_nxt = '0;
                    state_nxt   = CHECK;
                end
            end
            default: state_nxt = SCAN;
        endcase

`ifdef DWRR_STRICT0_EN
        // Strict requester 0 pre-empts the round robin outside of an active grant.
        if ((state == SCAN || state == CHECK) && reqs[0] && !blk) begin
            clr_vec     = '0;
            add_vec     = '0;
            ptr_nxt     = '0;
            gnt_nxt     = '0;
            gnt_nxt[0]  = 1'b1;
            gnt_len_nxt = eff_len0;
            state_nxt   = GRANT;
            strict_nxt  = 1'b1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            ptr     <= '0;
            gnt     <= '0;
            gnt_len <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
            gnt_len <= gnt_len_nxt;
            busy    <= (state_nxt == GRANT);
        end
    end

`ifdef DWRR_STRICT0_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            strict_q <= 1'b0;
        end else begin
            strict_q <= strict_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_dwrr_sched.sv
// Directed self-checking bench for dwrr_sched (default build, 4 requesters, 8-bit fields).
module tb_dwrr_sched;

    localparam int unsigned N = 4;
    localparam int unsigned Q = 8;
    localparam int unsigned L = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     reqs;
    logic [N*L-1:0]   req_lens;
    logic [N*Q-1:0]   input_quantums;
    logic             blk;
    logic             done;
    logic [N-1:0]     gnt;
    logic [L-1:0]     gnt_len;
    logic             busy;

    int tests_run = 0;
    int tests_failed = 0;

    int exp_fair [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_wgt  [8] = '{0, 0, 1, 2, 3, 0, 0, 1};

    dwrr_sched #(
        .NUM_REQS (N),
        .QWID     (Q),
        .LWID     (L)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .reqs           (reqs),
        .req_lens       (req_lens),
        .input_quantums (input_quantums),
        .blk            (blk),
        .done           (done),
        .gnt            (gnt),
        .gnt_len        (gnt_len),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a grant, then check who got it and for how long.
    task automatic wait_grant(input string tag, input int idx, input int len);
        int n;
        n = 0;
        while (gnt == '0 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_gnt"}, 32'(gnt), 32'(1) << idx);
        chk({tag, "_len"}, 32'(gnt_len), 32'(len));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic pulse_done(input string tag);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
        chk({tag, "_len_clr"}, 32'(gnt_len), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        reqs           = '0;
        req_lens       = '0;
        input_quantums = '0;
        blk            = 1'b0;
        done           = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_len", 32'(gnt_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) chk("rst_def", 32'(dut.def_cnt[i]), 32'd0);

        // Fairness: equal quantums and lengths
        reqs           = 4'hF;
        input_quantums = {8'd8, 8'd8, 8'd8, 8'd8};
        req_lens       = {8'd8, 8'd8, 8'd8, 8'd8};
        rst            = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_grant("fair", exp_fair[k], 8);
            if (k == 0) begin
                tick();
                tick();
                chk("fair_hold", 32'(gnt), 32'd1);
            end
            pulse_done("fair");
            chk("fair_def", 32'(dut.def_cnt[exp_fair[k]]), 32'd0);
        end

        // Weighted: requester 0 has twice the quantum
        reqs           = 4'hF;
        input_quantums = {8'd8, 8'd8, 8'd8, 8'd16};
        req_lens       = {8'd8, 8'd8, 8'd8, 8'd8};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            wait_grant("wgt", exp_wgt[k], 8);
            pulse_done("wgt");
        end

        // Deficit carry: len 12 > quantum 8 on requester 1
        reqs           = 4'b0010;
        input_quantums = {8'd0, 8'd0, 8'd8, 8'd0};
        req_lens       = {8'd0, 8'd0, 8'd12, 8'd0};
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        chk("carry_def_r1", 32'(dut.def_cnt[1]), 32'd8);
        chk("carry_nogrant", 32'(gnt), 32'd0);
        wait_grant("carry", 1, 12);
        chk("carry_def_r2", 32'(dut.def_cnt[1]), 32'd16);
        reqs = 4'b0000;
        pulse_done("carry");
        chk("carry_def_after", 32'(dut.def_cnt[1]), 32'd4);

        // Empty clear: requester 2 drops with deficit 5
        reqs           = 4'b0100;
        input_quantums = {8'd0, 8'd5, 8'd0, 8'd0};
        req_lens       = {8'd0, 8'd10, 8'd0, 8'd0};
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        chk("empty_def5", 32'(dut.def_cnt[2]), 32'd5);
        reqs = 4'b0000;
        tick();
        chk("empty_clr", 32'(dut.def_cnt[2]), 32'd0);

        // blk holds CHECK; done ignored outside GRANT; blk/req drop do not abort a grant
        reqs           = 4'b0001;
        input_quantums = {8'd0, 8'd0, 8'd0, 8'd12};
        req_lens       = {8'd0, 8'd0, 8'd0, 8'd8};
        blk            = 1'b1;
        do_reset();
        tick();
        tick();
        done = 1'b1;
        tick();
        tick();
        tick();
        done = 1'b0;
        chk("blk_nogrant", 32'(gnt), 32'd0);
        chk("blk_busy", 32'(busy), 32'd0);
        chk("blk_def_kept", 32'(dut.def_cnt[0]), 32'd12);
        blk = 1'b0;
        tick();
        chk("blk_rel_gnt", 32'(gnt), 32'd1);
        chk("blk_rel_len", 32'(gnt_len), 32'd8);
        blk  = 1'b1;
        reqs = 4'b0000;
        tick();
        tick();
        tick();
        chk("blk_hold_gnt", 32'(gnt), 32'd1);
        chk("blk_hold_busy", 32'(busy), 32'd1);
        pulse_done("blk");
        chk("blk_deduct", 32'(dut.def_cnt[0]), 32'd4);
        tick();
        chk("blk_drop_clr", 32'(dut.def_cnt[0]), 32'd0);
        blk = 1'b0;

        // Saturation: 200 + 200 clamps to 255, which then covers len 255
        reqs           = 4'b0001;
        input_quantums = {8'd0, 8'd0, 8'd0, 8'd200};
        req_lens       = {8'd0, 8'd0, 8'd0, 8'd255};
        do_reset();
        tick();
        tick();
        chk("sat_def200", 32'(dut.def_cnt[0]), 32'd200);
        wait_grant("sat", 0, 255);
        chk("sat_def255", 32'(dut.def_cnt[0]), 32'd255);
        reqs = 4'b0000;
        pulse_done("sat");
        chk("sat_after", 32'(dut.def_cnt[0]), 32'd0);

        // Zero length counts as 1
        reqs           = 4'b0001;
        input_quantums = {8'd0, 8'd0, 8'd0, 8'd8};
        req_lens       = {8'd0, 8'd0, 8'd0, 8'd0};
        do_reset();
        wait_grant("zlen", 0, 1);
        reqs = 4'b0000;
        pulse_done("zlen");
        chk("zlen_def", 32'(dut.def_cnt[0]), 32'd7);

        // Reset mid-GRANT overrides done; then 3-cycle grant latency
        reqs           = 4'b0001;
        input_quantums = {8'd0, 8'd0, 8'd0, 8'd8};
        req_lens       = {8'd0, 8'd0, 8'd0, 8'd8};
        do_reset();
        wait_grant("mid", 0, 8);
        rst  = 1'b1;
        done = 1'b1;
        tick();
        chk("mid_gnt", 32'(gnt), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_len", 32'(gnt_len), 32'd0);
        for (int i = 0; i < 4; i++) chk("mid_def", 32'(dut.def_cnt[i]), 32'd0);
        tick();
        rst  = 1'b0;
        done = 1'b0;
        tick();
        tick();
        chk("lat_c2", 32'(gnt), 32'd0);
        tick();
        chk("lat_c3", 32'(gnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dwrr_sched.md
DWRR_SCHED -- requirements
Module: dwrr_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of requesters.
REQ-002 SHALL have parameter QWID, default 8, width of quantum and deficit counter.
REQ-003 SHALL have parameter LWID, default 8, width of packet length; LWID <= QWID.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port reqs  input  NUM_REQS  per-requester "head packet pending".
REQ-007 SHALL have port req_lens  input  NUM_REQS*LWID  head packet length of requester i at [(i+1)*LWID-1:i*LWID].
REQ-008 SHALL have port input_quantums  input  NUM_REQS*QWID  per-requester quantum, same packing.
REQ-009 SHALL have port blk  input  1  stall: no new grant while high.
REQ-010 SHALL have port done  input  1  datapath pulse: granted packet fully transferred.
REQ-011 SHALL have port gnt  output  NUM_REQS  registered one-hot grant, all-zero when idle.
REQ-012 SHALL have port gnt_len  output  LWID  length of granted packet, 0 when no grant.
REQ-013 SHALL have port busy  output  1  high while in GRANT state.

Function
REQ-014 SHALL implement FSM states SCAN, REFILL, CHECK, GRANT, sequencing one requester pointer ptr (CNTWID=$clog2(NUM_REQS) bits).
REQ-015 SCAN: if reqs[ptr]=0, def_cnt[ptr] SHALL clear to 0, ptr SHALL advance (wrap NUM_REQS-1 -> 0), state stays SCAN; else go to REFILL.
REQ-016 REFILL: def_cnt[ptr] SHALL add quantums[ptr] once per turn, saturating at 2^QWID-1; next state CHECK.
REQ-017 CHECK: if reqs[ptr]=0, clear def_cnt[ptr], advance ptr, go to SCAN; else if blk=1, stay CHECK; else if def_cnt[ptr] >= eff_len, register gnt[ptr]=1 and gnt_len=eff_len, go to GRANT; else keep def_cnt, advance ptr, go to SCAN.
REQ-018 eff_len SHALL equal req_lens[ptr], except length 0 SHALL be treated as 1.
REQ-019 GRANT: gnt and gnt_len SHALL hold stable until done=1; on done, def_cnt[ptr] SHALL decrement by the latched gnt_len, gnt/gnt_len SHALL clear the next cycle, state returns to CHECK (same ptr, no refill).
REQ-020 done SHALL be ignored outside GRANT; blk SHALL NOT abort an active grant.
REQ-021 Grant latency: gnt SHALL rise the cycle after the CHECK cycle that qualifies it; minimum 3 cycles from reqs rising at an idle ptr.
REQ-022 Deficit counters of non-selected requesters SHALL never change.
REQ-023 reqs deasserting during GRANT SHALL NOT drop gnt; the deduction still applies.

Reset
REQ-024 On rst: state=SCAN, ptr=0, all def_cnt=0, gnt=0, gnt_len=0, busy=0, taking effect at the next rising edge and overriding every other event including done.

Configuration
REQ-025 Macro DWRR_STRICT0_EN, when defined, SHALL make requester 0 strict-priority: in SCAN or CHECK with reqs[0]=1 and blk=0, ptr SHALL jump to 0 and grant with no deficit check or deduction (def_cnt[0] untouched).
REQ-026 Without DWRR_STRICT0_EN, requester 0 SHALL be scheduled as any other requester.

Structure
REQ-027 Package dwrr_pkg SHALL hold the FSM state enum and the ptr-wrap and saturating-add helper functions.
REQ-028 One sub-module dwrr_defcnt (per-requester deficit counter cell: clear, saturating add, subtract, enable) SHALL be instantiated NUM_REQS times.

Verification
REQ-029 Reset: rst=1 for 2 cycles mid-GRANT -> gnt=0, busy=0, all def_cnt=0 next cycle.
REQ-030 Fairness: all reqs=1, quantums all 8, lens all 8, done 1 cycle after each gnt -> grants cycle 0,1,2,3,0,... one each per round.
REQ-031 Weighted: quantums {16,8,8,8}, lens 8 -> requester 0 receives 2 grants per round, others 1.
REQ-032 Deficit carry: quantum 8, len 12 on requester 1 alone -> no grant round 1 (def 8), grant round 2 (def 16 -> 4 after done).
REQ-033 Empty clear and blk: requester 2 drops reqs with def 5 -> def_cnt[2]=0; blk=1 in CHECK -> gnt stays 0 until blk=0.
REQ-034 Saturation/zero length: quantum 255 repeated without grants -> def_cnt holds 255; len 0 -> gnt_len=1, deduction 1.
